// File: rtl/flex_stp_deser_if.sv
// Bit-stream inputs and word-handshake outputs of flex_stp_deser.
// The master side drives the bit stream and consumes words; the slave side is the deserializer.
interface flex_stp_deser_if #(
    parameter int unsigned NUM_BITS = 8,
    parameter int unsigned CW       = $clog2(NUM_BITS)
);
    logic                shift_enable;
    logic                serial_in;
    logic                msb_first;
    logic                clear;
    logic                data_ready;
    logic [NUM_BITS-1:0] parallel_out;
    logic [NUM_BITS-1:0] data_out;
    logic                data_valid;
    logic                overrun;
    logic [CW-1:0]       bit_count;

    modport master (
        output shift_enable, serial_in, msb_first, clear, data_ready,
        input  parallel_out, data_out, data_valid, overrun, bit_count
    );

    modport slave (
        input  shift_enable, serial_in, msb_first, clear, data_ready,
        output parallel_out, data_out, data_valid, overrun, bit_count
    );
endinterface

// File: rtl/flex_stp_deser.sv
// Serial-to-parallel deserializer with selectable shift direction, word framing,
// a holding register with valid/ready handshake and a sticky overrun flag.
module flex_stp_deser #(
    parameter int unsigned NUM_BITS = 8,
    parameter int unsigned CW       = $clog2(NUM_BITS)
) (
    input logic              clk,
    input logic              rst,
    flex_stp_deser_if.slave  bus
);

    logic [NUM_BITS-1:0] sr_q, sr_d;
    logic [NUM_BITS-1:0] dout_q, dout_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic                ovr_q, ovr_d;
    logic                last_bit;
    logic                complete;
    logic                accept;

    assign last_bit = (cnt_q == CW'(NUM_BITS - 1));
    assign complete = bus.shift_enable && !bus.clear && last_bit;
    assign accept   = valid_q && bus.data_ready;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (bus.clear) begin
            sr_d  = '1;
            cnt_d = '0;
        end else if (bus.shift_enable) begin
            sr_d  = bus.msb_first ? {sr_q[NUM_BITS-2:0], bus.serial_in}
                                  : {bus.serial_in, sr_q[NUM_BITS-1:1]};
            cnt_d = last_bit ? '0 : cnt_q + CW'(1);
        end
    end

    // Completion outranks acceptance: a new word landing on an accept edge stays valid.
    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (bus.clear) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else if (complete) begin
            dout_d  = sr_d;
            valid_d = 1'b1;
            if (valid_q && !bus.data_ready) begin
                ovr_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q    <= '1;
            dout_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.parallel_out = sr_q;
    assign bus.data_out     = dout_q;
    assign bus.data_valid   = valid_q;
    assign bus.overrun      = ovr_q;
    assign bus.bit_count    = cnt_q;

endmodule

// File: doc/flex_stp_deser.md
# flex_stp_deser

Parametrised serial-to-parallel deserializer: the next generation of the team's flex serial-to-parallel shift register. It adds a runtime-selectable shift direction, a bit counter with word framing, and a holding register with a valid/ready handshake and a sticky overrun flag. It sits between a bit-level receiver (which supplies `shift_enable` strobes) and word-level consumer logic such as a FIFO or a packet FSM.

## Interface
- `NUM_BITS`, default 8: word width, ≥ 2.
- `CW`, default `$clog2(NUM_BITS)`: width of `bit_count`; derived, do not override.
- `clk` in, 1: clock, rising edge.
- `rst` in, 1: asynchronous, active-high reset. One clock domain; polarity and asynchronous behaviour are fixed.
- `shift_enable` in, 1: sample `serial_in` at this edge.
- `serial_in` in, 1: serial data bit.
- `msb_first` in, 1: direction for the current shift.
  - 1: shift toward the MSB; the new bit enters at [0].
  - 0: shift toward the LSB; the new bit enters at [NUM_BITS-1].
- `clear` in, 1: synchronous restart.
- `data_ready` in, 1: consumer accepts `data_out` this cycle.
- `parallel_out` out, NUM_BITS: live shift-register contents.
- `data_out` out, NUM_BITS: last completed word (holding register).
- `data_valid` out, 1: `data_out` holds an unaccepted word.
- `overrun` out, 1: sticky; a word completed while the previous word was still unaccepted.
- `bit_count` out, CW: bits shifted into the current word, range 0..NUM_BITS-1.

## Operation
- Shift register `sr` drives `parallel_out`. On a `shift_enable` edge:
  - `msb_first`=1: `sr` ← {`sr`[N-2:0], `serial_in`}.
  - `msb_first`=0: `sr` ← {`serial_in`, `sr`[N-1:1]}.
  - `msb_first` is sampled on every shift. Changing it mid-word is legal; each bit follows the setting at its own edge.
- `bit_count`:
  - Increments on each shift.
  - On the shift where `bit_count`==N-1, the word completes and `bit_count` wraps to 0.
  - Holds when `shift_enable`=0.
- Word complete: `data_out` ← the post-shift value of `sr` (same edge), and `data_valid` ← 1. `sr` is not cleared; the next word shifts over it.
- Acceptance: at an edge with `data_valid`=1 and `data_ready`=1, the word is consumed. `data_ready` is ignored while `data_valid`=0.
- Edge priority, highest first:
  1. `clear`: `sr` ← all ones, `bit_count` ← 0, `data_valid` ← 0, `overrun` ← 0. `data_out` holds. `shift_enable` is ignored in that cycle.
  2. Completion and acceptance on the same edge: `data_out` loads the new word, `data_valid` stays 1, `overrun` unchanged.
  3. Completion while `data_valid`=1 and `data_ready`=0: `data_out` is overwritten with the newer word, `data_valid` stays 1, `overrun` ← 1.
  4. Acceptance only: `data_valid` ← 0.
- `overrun` is cleared only by `clear` or `rst`.

## Timing
- Reset values (asynchronous, immediate on `rst`):
  - `parallel_out` = all ones.
  - `data_out` = 0.
  - `data_valid` = 0, `overrun` = 0, `bit_count` = 0.
- All outputs are registered; there are no combinational input-to-output paths.
- Latency:
  - `parallel_out` and `bit_count` reflect a shift in the cycle after its edge.
  - `data_out` and `data_valid` are valid in the cycle after the edge that samples the Nth bit.
- Throughput: one bit per cycle sustained. Back-to-back words need no idle cycles.
- Minimum `data_valid` high time is 1 cycle (when `data_ready` is held at 1).
- Reset mid-word: the partial word and any pending `data_out` are discarded. The first post-reset shift counts as bit 1.
- `rst` deasserted with `shift_enable`=1: the first shift happens at the first rising edge with `rst` low.

## Test plan
All scenarios use NUM_BITS=8.
1. Reset: assert `rst` mid-word (`bit_count`=3) → outputs go immediately to FF/00/valid 0/overrun 0/count 0. Release → a fresh 8-bit word frames correctly.
2. MSB-first: `msb_first`=1, bits 1,1,0,0,0,0,0,1 on consecutive edges → `data_out`=8'hC1, `data_valid`=1 the cycle after the 8th edge, `bit_count`=0.
3. LSB-first, with gaps: `msb_first`=0, same bit sequence, random idle cycles between shifts → `data_out`=8'h83; `bit_count` holds during gaps; `data_valid` only after the 8th shift.
4. Back-to-back, consumer ready: `data_ready`=1, words 8'h3C then 8'h5A streamed with no gap → each word has `data_valid` high for exactly one cycle, `data_out` values correct, `overrun`=0.
5. Overrun: `data_ready`=0, words 8'hAA then 8'h55 → `overrun`=1 and `data_out`=8'h55 after the second word. A one-cycle `data_ready` pulse then gives `data_valid`=0 with `overrun` still 1.
6. Clear: after 3 bits shifted, pulse `clear` together with `shift_enable`=1 → `bit_count`=0, `parallel_out`=8'hFF, `overrun`=0, `data_valid`=0. The next 8 shifts form a complete word.
